// File: rtl/hazard_stall_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl_if
// Bundles the pipeline-side signals of the hazard/stall controller.
//   D_*  : source operands of the instruction in D (numbers, use flags, Tuse),
//          plus D_UsesMD for any HI/LO or mult/div instruction
//   E_*  : destination/Tnew of the instruction in E, mult/div issue strobe
//   M_*  : destination/Tnew of the instruction in M
//   F_En, D_En, E_Clr, Stall : stall controls for the F/D/E registers
//   MD_Busy, MD_Err          : mult/div busy window and sticky violation flag
//   StallCnt                 : saturating stall-cycle counter
// Modports: master = pipeline datapath, slave = controller.
// -----------------------------------------------------------------------------
interface hazard_stall_ctrl_if;
  logic [4:0]  D_Rs;
  logic [4:0]  D_Rt;
  logic        D_UseRs;
  logic        D_UseRt;
  logic [1:0]  D_TuseRs;
  logic [1:0]  D_TuseRt;
  logic        D_UsesMD;
  logic [4:0]  E_A3;
  logic [1:0]  E_Tnew;
  logic [4:0]  M_A3;
  logic [1:0]  M_Tnew;
  logic        E_MDStart;
  logic        E_MDIsDiv;
  logic        F_En;
  logic        D_En;
  logic        E_Clr;
  logic        Stall;
  logic        MD_Busy;
  logic        MD_Err;
  logic [31:0] StallCnt;

  modport master (
    output D_Rs, D_Rt, D_UseRs, D_UseRt, D_TuseRs, D_TuseRt, D_UsesMD,
           E_A3, E_Tnew, M_A3, M_Tnew, E_MDStart, E_MDIsDiv,
    input  F_En, D_En, E_Clr, Stall, MD_Busy, MD_Err, StallCnt
  );

  modport slave (
    input  D_Rs, D_Rt, D_UseRs, D_UseRt, D_TuseRs, D_TuseRt, D_UsesMD,
           E_A3, E_Tnew, M_A3, M_Tnew, E_MDStart, E_MDIsDiv,
    output F_En, D_En, E_Clr, Stall, MD_Busy, MD_Err, StallCnt
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
// Hazard and stall controller for the five-stage MIPS core.
//   - Detects RAW hazards forwarding cannot cover (producer Tnew > consumer Tuse)
//   - Times the mult/div busy window with a down-counter
//   - Counts stall cycles (saturating) for performance debug
// Ports:
//   Clk   : rising-edge clock
//   Reset : synchronous, active-high
//   bus   : hazard_stall_ctrl_if.slave (pipeline inputs, stall/status outputs)
// Parameters:
//   MULT_CYCLES / DIV_CYCLES : busy cycles added after a mult / div issues in E
//   CNT_W                    : MD counter width, must hold max(MULT, DIV)
//   STALL_CNT_W              : stall counter width (1..32), zero-extended onto
//                              StallCnt; 32 in the core, narrower only to make
//                              saturation observable in short simulations
// -----------------------------------------------------------------------------
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4,
  parameter int STALL_CNT_W = 32
) (
  input logic               Clk,
  input logic               Reset,
  hazard_stall_ctrl_if.slave bus
);

  logic [CNT_W-1:0]       md_cnt_q, md_cnt_d;
  logic                   md_err_q, md_err_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic haz_rs, haz_rt, haz_md;
  logic md_busy, stall;

  // A source conflicts only if a later stage will write it and its result is
  // not ready by the time this instruction consumes it. E and M matches are
  // ORed, so a double match is still a single hazard.
  assign haz_rs = bus.D_UseRs && (bus.D_Rs != 5'd0) &&
                  (((bus.E_A3 == bus.D_Rs) && (bus.E_Tnew > bus.D_TuseRs)) ||
                   ((bus.M_A3 == bus.D_Rs) && (bus.M_Tnew > bus.D_TuseRs)));

  assign haz_rt = bus.D_UseRt && (bus.D_Rt != 5'd0) &&
                  (((bus.E_A3 == bus.D_Rt) && (bus.E_Tnew > bus.D_TuseRt)) ||
                   ((bus.M_A3 == bus.D_Rt) && (bus.M_Tnew > bus.D_TuseRt)));

  // Busy covers the issue cycle itself, so a dependent op in D holds off
  // while the mult/div is still in E.
  assign md_busy = bus.E_MDStart || (md_cnt_q != '0);
  assign haz_md  = bus.D_UsesMD && md_busy;
  assign stall   = haz_rs || haz_rt || haz_md;

  assign bus.Stall    = stall;
  assign bus.F_En     = ~stall;
  assign bus.D_En     = ~stall;
  assign bus.E_Clr    = stall;
  assign bus.MD_Busy  = md_busy;
  assign bus.MD_Err   = md_err_q;
  assign bus.StallCnt = 32'(stall_cnt_q);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    md_cnt_d    = md_cnt_q;
    md_err_d    = md_err_q;
    stall_cnt_d = stall_cnt_q;

    if (bus.E_MDStart && (md_cnt_q == '0)) begin
      md_cnt_d = bus.E_MDIsDiv ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (bus.E_MDStart) begin
      // Issue while busy: a well-formed pipeline never does this. Drop the
      // start, keep the current window running, flag it permanently.
      md_cnt_d = md_cnt_q - 1'b1;
      md_err_d = 1'b1;
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - 1'b1;
    end

    if (stall && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    if (Reset) begin
      md_cnt_q    <= '0;
      md_err_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      md_err_q    <= md_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_ctrl
// Scoreboarded bench: the stimulus process computes each cycle's expected
// outputs from the hazard and mult/div timing rules and queues them; a monitor
// on the falling edge pops and compares. A second instance with a 4-bit stall
// counter shares the stimulus so saturation is reachable.
// -----------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs, rt;
    logic       urs, urt;
    logic [1:0] trs, trt;
    logic       umd;
    logic [4:0] ea3;
    logic [1:0] etn;
    logic [4:0] ma3;
    logic [1:0] mtn;
    logic       st, dv;
  } stim_t;

  typedef struct packed {
    logic        stall;
    logic        md_busy;
    logic        md_err;
    logic [31:0] cnt;
    logic [31:0] cnt_n;
  } exp_t;

  logic clk = 1'b0;
  logic Reset;

  hazard_stall_ctrl_if bus ();
  hazard_stall_ctrl_if bus_n ();

  hazard_stall_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(4))
    dut (.Clk(clk), .Reset(Reset), .bus(bus.slave));

  hazard_stall_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(4),
                      .STALL_CNT_W(4))
    dut_n (.Clk(clk), .Reset(Reset), .bus(bus_n.slave));

  assign bus_n.D_Rs      = bus.D_Rs;
  assign bus_n.D_Rt      = bus.D_Rt;
  assign bus_n.D_UseRs   = bus.D_UseRs;
  assign bus_n.D_UseRt   = bus.D_UseRt;
  assign bus_n.D_TuseRs  = bus.D_TuseRs;
  assign bus_n.D_TuseRt  = bus.D_TuseRt;
  assign bus_n.D_UsesMD  = bus.D_UsesMD;
  assign bus_n.E_A3      = bus.E_A3;
  assign bus_n.E_Tnew    = bus.E_Tnew;
  assign bus_n.M_A3      = bus.M_A3;
  assign bus_n.M_Tnew    = bus.M_Tnew;
  assign bus_n.E_MDStart = bus.E_MDStart;
  assign bus_n.E_MDIsDiv = bus.E_MDIsDiv;

  always #5 clk = ~clk;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference state: cycle index, last cycle of the current busy window,
  // sticky error and stall count since the last reset.
  int     cyc       = 0;
  int     win_end   = -1;
  bit     err_m     = 1'b0;
  longint stalls_m  = 0;
  int     busy_seen = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic bit src_haz(input logic use_f, input logic [4:0] r,
                                 input logic [1:0] tuse, input stim_t s);
    if (!use_f || r == 5'd0) return 1'b0;
    return (s.ea3 == r && s.etn > tuse) || (s.ma3 == r && s.mtn > tuse);
  endfunction

  task automatic drive(input stim_t s);
    exp_t e;
    bit   active, busy;
    @(posedge clk);
    #1;
    Reset         = s.rst;
    bus.D_Rs      = s.rs;
    bus.D_Rt      = s.rt;
    bus.D_UseRs   = s.urs;
    bus.D_UseRt   = s.urt;
    bus.D_TuseRs  = s.trs;
    bus.D_TuseRt  = s.trt;
    bus.D_UsesMD  = s.umd;
    bus.E_A3      = s.ea3;
    bus.E_Tnew    = s.etn;
    bus.M_A3      = s.ma3;
    bus.M_Tnew    = s.mtn;
    bus.E_MDStart = s.st;
    bus.E_MDIsDiv = s.dv;

    active    = (cyc <= win_end);
    busy      = s.st || active;
    e.stall   = src_haz(s.urs, s.rs, s.trs, s) || src_haz(s.urt, s.rt, s.trt, s) ||
                (s.umd && busy);
    e.md_busy = busy;
    e.md_err  = err_m;
    e.cnt     = (stalls_m >= 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(stalls_m);
    e.cnt_n   = (stalls_m >= 15) ? 32'd15 : 32'(stalls_m);
    sb_q.push_back(e);

    #1;
    if (bus.MD_Busy === 1'b1) busy_seen++;

    if (s.rst) begin
      win_end  = -1;
      err_m    = 1'b0;
      stalls_m = 0;
    end else begin
      if (s.st && !active) win_end = cyc + (s.dv ? DIV_N : MULT_N);
      else if (s.st)       err_m = 1'b1;
      if (e.stall) stalls_m++;
    end
    cyc++;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("stall",       32'(bus.Stall),   32'(e.stall));
      check("f_en",        32'(bus.F_En),    32'(!e.stall));
      check("d_en",        32'(bus.D_En),    32'(!e.stall));
      check("e_clr",       32'(bus.E_Clr),   32'(e.stall));
      check("md_busy",     32'(bus.MD_Busy), 32'(e.md_busy));
      check("md_err",      32'(bus.MD_Err),  32'(e.md_err));
      check("stall_cnt",   bus.StallCnt,     e.cnt);
      check("stall_cnt_n", bus_n.StallCnt,   e.cnt_n);
    end
  end

  initial begin
    stim_t s;
    Reset = 1'b1;
    bus.D_Rs = '0; bus.D_Rt = '0; bus.D_UseRs = 1'b0; bus.D_UseRt = 1'b0;
    bus.D_TuseRs = '0; bus.D_TuseRt = '0; bus.D_UsesMD = 1'b0;
    bus.E_A3 = '0; bus.E_Tnew = '0; bus.M_A3 = '0; bus.M_Tnew = '0;
    bus.E_MDStart = 1'b0; bus.E_MDIsDiv = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state with idle inputs.
    drive(idle());

    // Load-use in E, then the same producer in M with Tnew 1: no stall.
    s = idle(); s.ea3 = 5'd8; s.etn = 2'd2; s.rs = 5'd8; s.urs = 1'b1; s.trs = 2'd1;
    drive(s);
    s = idle(); s.ma3 = 5'd8; s.mtn = 2'd1; s.rs = 5'd8; s.urs = 1'b1; s.trs = 2'd1;
    drive(s);

    // Register 0 never hazards; Tnew 0 in M never hazards.
    s = idle(); s.ea3 = 5'd0; s.etn = 2'd2; s.rs = 5'd0; s.urs = 1'b1;
    drive(s);
    s = idle(); s.ma3 = 5'd5; s.mtn = 2'd0; s.rt = 5'd5; s.urt = 1'b1;
    drive(s);

    // Mult followed by a dependent mflo held in D.
    s = idle(); s.rst = 1'b1; drive(s);
    s = idle(); s.st = 1'b1; s.umd = 1'b1; drive(s);
    s = idle(); s.umd = 1'b1;
    repeat (6) drive(s);
    drive(idle());
    check("mult_stallcnt", bus.StallCnt, 32'd6);

    // Div busy window length.
    s = idle(); s.rst = 1'b1; drive(s);
    busy_seen = 0;
    s = idle(); s.st = 1'b1; s.dv = 1'b1; drive(s);
    repeat (13) drive(idle());
    check("div_busy_len", 32'(busy_seen), 32'd11);

    // Re-issue during a mult: sticky error, window unchanged.
    s = idle(); s.rst = 1'b1; drive(s);
    s = idle(); s.st = 1'b1; drive(s);
    drive(idle());
    s = idle(); s.st = 1'b1; drive(s);
    repeat (6) drive(idle());
    check("viol_err_sticky", 32'(bus.MD_Err), 32'd1);

    // Reset in the middle of a div.
    s = idle(); s.st = 1'b1; s.dv = 1'b1; s.rst = 1'b1; drive(s);
    s = idle(); s.st = 1'b1; s.dv = 1'b1; drive(s);
    s = idle(); s.umd = 1'b1;
    repeat (3) drive(s);
    s.rst = 1'b1; drive(s);
    s.rst = 1'b0; drive(s);
    check("rst_mid_div_busy", 32'(bus.MD_Busy), 32'd0);

    // Long forced stall: narrow counter saturates.
    s = idle(); s.ea3 = 5'd1; s.etn = 2'd2; s.rs = 5'd1; s.urs = 1'b1; s.trs = 2'd0;
    repeat (20) drive(s);
    drive(idle());
    check("sat_narrow", bus_n.StallCnt, 32'd15);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 500; i++) begin
      s.rst = ($urandom_range(0, 49) == 0);
      s.rs  = 5'($urandom_range(0, 3));
      s.rt  = 5'($urandom_range(0, 3));
      s.urs = 1'($urandom_range(0, 1));
      s.urt = 1'($urandom_range(0, 1));
      s.trs = 2'($urandom_range(0, 2));
      s.trt = 2'($urandom_range(0, 2));
      s.umd = ($urandom_range(0, 3) == 0);
      s.ea3 = 5'($urandom_range(0, 3));
      s.etn = 2'($urandom_range(0, 2));
      s.ma3 = 5'($urandom_range(0, 3));
      s.mtn = 2'($urandom_range(0, 1));
      s.st  = ($urandom_range(0, 7) == 0);
      s.dv  = 1'($urandom_range(0, 1));
      drive(s);
    end

    repeat (2) @(posedge clk);
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline hazard and stall controller for the five-stage MIPS core. It drives the enable and clear inputs of the F/D/E pipeline registers. It detects RAW hazards that forwarding cannot resolve, using Tuse/Tnew comparison. It also sequences the multiply/divide unit's busy window with an internal latency counter. A saturating stall-cycle counter is provided for performance debug.

## Interface
Parameters:
- `MULT_CYCLES`, 5: busy cycles added after a mult/multu issues in E.
- `DIV_CYCLES`, 10: busy cycles added after a div/divu issues in E.
- `CNT_W`, 4: width of the MD latency counter. Must hold `max(MULT_CYCLES, DIV_CYCLES)`.

Ports:
- `Clk` in 1: the single clock. All state updates on the rising edge.
- `Reset` in 1: synchronous, active-high.
- `D_Rs`, `D_Rt` in 5 each: source register numbers of the instruction in D.
- `D_UseRs`, `D_UseRt` in 1 each: the D instruction reads that source.
- `D_TuseRs`, `D_TuseRt` in 2 each: cycles until that operand is consumed. 0 = in D, 1 = in E, 2 = in M.
- `D_UsesMD` in 1: the D instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- `E_A3` in 5: destination register of the instruction in E. 0 means no write.
- `E_Tnew` in 2: cycles until the E result is available.
- `M_A3` in 5: destination register of the instruction in M.
- `M_Tnew` in 2: cycles until the M result is available.
- `E_MDStart` in 1: a mult/div is issuing from E this cycle.
- `E_MDIsDiv` in 1: qualifies `E_MDStart`. 1 = div/divu, 0 = mult/multu.
- `F_En` out 1: PC enable.
- `D_En` out 1: enable of the F/D register.
- `E_Clr` out 1: clear of the D/E register, ORed into its `Reset`.
- `Stall` out 1: a stall is active this cycle.
- `MD_Busy` out 1: the MD unit is busy.
- `MD_Err` out 1: sticky flag for a protocol violation.
- `StallCnt` out 32: saturating count of stall cycles.

## Operation
Register hazard (combinational):
- `HazRs` is true when `D_UseRs` is set, `D_Rs` is not 0, and either of these holds:
  - `E_A3 == D_Rs` and `E_Tnew > D_TuseRs`.
  - `M_A3 == D_Rs` and `M_Tnew > D_TuseRs`.
- `HazRt` uses the same rule with `D_UseRt`, `D_Rt` and `D_TuseRt`.
- Register 0 never causes a hazard.
- A match in both E and M is one hazard, not two.

MD sequencing:
- The latency counter `cnt` is `CNT_W` bits wide and 0 on reset.
- Each cycle, apply the first rule that matches:
  - If `E_MDStart` is 1 and `cnt == 0`, load `cnt <= E_MDIsDiv ? DIV_CYCLES : MULT_CYCLES`.
  - If `E_MDStart` is 1 and `cnt != 0`, this is a violation. The start is ignored, `cnt` decrements, and `MD_Err <= 1`.
  - If `cnt != 0`, decrement `cnt`.
  - Otherwise, hold `cnt`.
- `MD_Busy = E_MDStart | (cnt != 0)`.
- `HazMD = D_UsesMD & MD_Busy`.

Stall generation:
- `Stall = HazRs | HazRt | HazMD`.
- `F_En = ~Stall`.
- `D_En = ~Stall`.
- `E_Clr = Stall`. This inserts a bubble into E.
- `Stall` depends only on D/E/M inputs and `cnt`. There is no combinational path from `F_En` or `D_En` back into `Stall`.

Stall counter:
- `StallCnt` increments by 1 each cycle that `Stall` is 1.
- It saturates at `32'hFFFF_FFFF`.

Reset behaviour:
- On reset: `cnt = 0`, `MD_Err = 0`, `StallCnt = 0`.
- The combinational outputs then follow their inputs. With idle inputs, `F_En = 1`, `D_En = 1`, `E_Clr = 0`, `Stall = 0` and `MD_Busy = 0`.
- A reset in the middle of an MD operation aborts the busy window immediately on the next cycle.
- `MD_Err` clears only on reset.

## Timing
- Hazard and stall outputs are combinational within the same cycle. They are valid before the edge at which F/D hold and E takes the bubble.
- An MD op in E at cycle t, with N = `MULT_CYCLES` or `DIV_CYCLES`:
  - `MD_Busy` is 1 for cycles t through t+N, which is N+1 cycles.
  - `cnt` is N at t+1 and reaches 0 at t+N+1.
  - A dependent MD instruction held in D stalls through t+N and advances at edge t+N+1.
- Because D-stage MD instructions stall while busy, a well-formed pipeline never asserts `E_MDStart` while `cnt != 0`. `MD_Err` is a checker for exactly that case.
- `StallCnt` reflects the cycle-t stall at t+1.

## Test plan
- Load-use: `E_A3 = 8`, `E_Tnew = 2`, D reads rs = 8 with `D_TuseRs = 1` → `Stall = 1`, `F_En = 0`, `E_Clr = 1` for that cycle. Then with `E_Tnew = 1` in M (`M_A3 = 8`, `M_Tnew = 1`) → no stall.
- Register 0: `E_A3 = 0`, `D_Rs = 0`, `E_Tnew = 2` → `Stall = 0`. Also `M_Tnew = 0` with a matching `M_A3` → `Stall = 0`.
- Mult then mflo: `E_MDStart = 1`, `E_MDIsDiv = 0` at cycle 0, and `D_UsesMD = 1` held → `Stall = 1` for cycles 0–5 and 0 at cycle 6. `StallCnt = 6` afterwards.
- Div: same sequence with `E_MDIsDiv = 1` → `MD_Busy` high for exactly 11 cycles.
- Violation: `E_MDStart` re-asserted at cycle 2 of a mult → `MD_Err = 1` from cycle 3 and stays 1. `cnt` still reaches 0 at cycle 6.
- Reset mid-div at cycle 4 → next cycle `MD_Busy = 0`, `StallCnt = 0`, `MD_Err = 0`. Preload `StallCnt` near saturation via a long forced stall → it stops at `FFFF_FFFF`.
